// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, error codes,
// wait-counter width and the address-error decode.
package dmem_pkg;

    localparam int unsigned WAIT_W = 4;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ADDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned, or any byte-address bit above the array's span is set.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, synchronous registered read, no reset.
module dmem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target-side data memory: one outstanding load/store via valid/ready, with a
// programmable wait-state latency and an address-error response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : WAIT_W'(WAIT_STATES - 1);

    state_t              state;
    state_t              next;
    logic [WAIT_W-1:0]   cnt;
    logic                write_q;
    logic                err_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;

    logic                accept;
    logic                req_err;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;

    assign accept  = (state == ST_IDLE) && req_valid;
    assign req_err = addr_error(req_addr, ADDR_W) ? ERR_ADDR : ERR_NONE;

    // The array is accessed on the edge entering RESP; with no wait states that
    // is the accept edge itself, so the live request feeds the array from IDLE.
    always_comb begin
        next      = state;
        mem_en    = 1'b0;
        mem_we    = write_q;
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        case (state)
            ST_IDLE: begin
                mem_we    = req_write;
                mem_addr  = req_addr[ADDR_W+1:2];
                mem_wdata = req_wdata;
                if (req_valid) begin
                    if (req_err || (WAIT_STATES == 0)) begin
                        next   = ST_RESP;
                        mem_en = !req_err;
                    end else begin
                        next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    next   = ST_RESP;
                    mem_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    next = ST_IDLE;
                end
            end
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            err_q   <= ERR_NONE;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= next;
            if (accept) begin
                write_q <= req_write;
                err_q   <= req_err;
                waddr_q <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                cnt     <= CNT_INIT;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !write_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance for the main
// sequence and a WAIT_STATES=0 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents one request from IDLE; lat = edges after the accept edge until resp_valid.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_consumed"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_rdata_clr"}, resp_rdata, 32'd0);
    endtask

    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        send(wr, addr, wd, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        finish_resp(tag);
    endtask

    logic [31:0] z_addr [4];
    logic [31:0] z_data [4];
    logic        z_wr   [4];
    logic [31:0] z_exp  [4];

    initial begin
        int lat;
        reset        = 1'b0;
        req_valid    = 1'b0; req_write   = 1'b0; req_addr   = '0; req_wdata   = '0; resp_ready   = 1'b0;
        z_req_valid  = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
        #12;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_z_resp_valid", {31'd0, z_resp_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Store then load the same word: 2 wait states each.
        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Misaligned load answers immediately with an error and leaves the array alone.
        xact("ld13", 1'b0, 32'h13, 32'h0, 0, 32'h0, 1'b1);
        xact("ld10b", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Out-of-range store must not alias onto word 0.
        xact("st00", 1'b1, 32'h0, 32'hCAFEF00D, 2, 32'h0, 1'b0);
        xact("st1000", 1'b1, 32'h0000_1000, 32'h55555555, 0, 32'h0, 1'b1);
        xact("ld00", 1'b0, 32'h0, 32'h0, 2, 32'hCAFEF00D, 1'b0);

        // Back-pressure: response held stable, stray request ignored.
        send(1'b0, 32'h10, 32'h0, lat);
        check("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'hDEADBEEF);
            check("bp_err", {31'd0, resp_err}, 32'd0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        finish_resp("bp");
        check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        xact("ld10c", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT drops the pending store.
        xact("st20", 1'b1, 32'h20, 32'h0BADF00D, 2, 32'h0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rw_in_wait", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rw_resp_rdata", resp_rdata, 32'd0);
        check("rw_resp_err", {31'd0, resp_err}, 32'd0);
        check("rw_req_ready", {31'd0, req_ready}, 32'd1);
        #12;
        reset = 1'b1;
        @(posedge clk); #1;
        xact("ld20", 1'b0, 32'h20, 32'h0, 2, 32'h0BADF00D, 1'b0);

        // Zero-wait instance: request held, resp_ready high, accept every 2 cycles.
        z_addr[0] = 32'h40; z_data[0] = 32'hA5A5A5A5; z_wr[0] = 1'b1; z_exp[0] = 32'h0;
        z_addr[1] = 32'h44; z_data[1] = 32'h5A5A5A5A; z_wr[1] = 1'b1; z_exp[1] = 32'h0;
        z_addr[2] = 32'h40; z_data[2] = 32'h0;        z_wr[2] = 1'b0; z_exp[2] = 32'hA5A5A5A5;
        z_addr[3] = 32'h44; z_data[3] = 32'h0;        z_wr[3] = 1'b0; z_exp[3] = 32'h5A5A5A5A;
        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            z_req_write = z_wr[k];
            z_req_addr  = z_addr[k];
            z_req_wdata = z_data[k];
            @(posedge clk); #1;
            check("z_resp_valid", {31'd0, z_resp_valid}, 32'd1);
            check("z_rdata", z_resp_rdata, z_exp[k]);
            check("z_err", {31'd0, z_resp_err}, 32'd0);
            check("z_busy", {31'd0, z_req_ready}, 32'd0);
            @(posedge clk); #1;
            check("z_idle_valid", {31'd0, z_resp_valid}, 32'd0);
            check("z_idle_ready", {31'd0, z_req_ready}, 32'd1);
        end
        z_req_valid  = 1'b0;
        z_resp_ready = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
